// File: rtl/sd_spi_responder.sv
// SD card SPI-mode responder: decodes 48-bit command frames, runs the card init handshake
// and serves single-block reads/writes from internal storage.
module sd_spi_responder #(
  parameter int unsigned BLOCKS        = 8,
  parameter int unsigned INIT_BUSY_CNT = 2,
  parameter int unsigned BUSY_BYTES    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        sclk,
  input  logic        mosi,
  output logic        miso,
  output logic        cmd_valid,
  output logic [5:0]  cmd_idx,
  output logic [31:0] cmd_arg,
  output logic        initialized
);

  localparam int unsigned BLK_W  = (BLOCKS > 1) ? $clog2(BLOCKS) : 1;
  localparam int unsigned ADDR_W = BLK_W + 9;
  localparam int unsigned DEPTH  = BLOCKS * 512;
  localparam int unsigned BUSY_W = (INIT_BUSY_CNT > 0) ? $clog2(INIT_BUSY_CNT + 1) : 1;

  typedef enum logic [3:0] {
    HUNT, CMD, NCR, RESP, RD_GAP, RD_TOKEN, RD_DATA, RD_CRC,
    WR_WAIT_TOKEN, WR_DATA, WR_CRC, WR_DRESP, WR_BUSY
  } state_e;

  logic cs_meta_q, cs_sync_q;
  logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
  logic mosi_meta_q, mosi_sync_q;

  state_e              state_q, state_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [6:0]          rx_sr_q, rx_sr_d;
  logic [37:0]         cmd_sr_q, cmd_sr_d;
  logic [8:0]          cnt_q, cnt_d;
  logic [7:0]          tx_q, tx_d;
  logic                miso_q, miso_d;
  logic                cmd_valid_q, cmd_valid_d;
  logic [5:0]          cmd_idx_q, cmd_idx_d;
  logic [31:0]         cmd_arg_q, cmd_arg_d;
  logic                init_q, init_d;
  logic                idle_q, idle_d;
  logic                app_q, app_d;
  logic [BUSY_W-1:0]   busy_q, busy_d;
  logic [7:0]          r1_q, r1_d;
  logic                r7_q, r7_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic [BLK_W-1:0]    blk_q, blk_d;

  logic                sclk_rise_c, sclk_fall_c;
  logic [7:0]          rx_byte_c;
  logic [7:0]          r7_byte_c;
  logic [BUSY_W-1:0]   busy_dec_c;
  logic [5:0]          new_idx_c;
  logic [31:0]         new_arg_c;
  logic                mem_we_c;
  logic [ADDR_W-1:0]   wr_addr_c, rd_addr_c;
  logic [7:0]          rd_data_q;
  logic [7:0]          mem_q [DEPTH];

  // Bring the SPI pins into the clk domain
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_meta_q   <= 1'b1;
      cs_sync_q   <= 1'b1;
      sclk_meta_q <= 1'b0;
      sclk_sync_q <= 1'b0;
      sclk_prev_q <= 1'b0;
      mosi_meta_q <= 1'b1;
      mosi_sync_q <= 1'b1;
    end else begin
      cs_meta_q   <= cs;
      cs_sync_q   <= cs_meta_q;
      sclk_meta_q <= sclk;
      sclk_sync_q <= sclk_meta_q;
      sclk_prev_q <= sclk_sync_q;
      mosi_meta_q <= mosi;
      mosi_sync_q <= mosi_meta_q;
    end
  end

  always_comb begin
    sclk_rise_c = sclk_sync_q & ~sclk_prev_q;
    sclk_fall_c = ~sclk_sync_q & sclk_prev_q;
    rx_byte_c   = {rx_sr_q, mosi_sync_q};
    new_idx_c   = cmd_sr_q[37:32];
    new_arg_c   = cmd_sr_q[31:0];
    busy_dec_c  = (busy_q == '0) ? '0 : busy_q - BUSY_W'(1);
    wr_addr_c   = {blk_q, cnt_q};
    rd_addr_c   = (state_q == RD_DATA) ? {blk_q, cnt_q + 9'd1} : {blk_q, 9'd0};
    case (cnt_q[1:0])
      2'd2:    r7_byte_c = 8'h01;
      2'd3:    r7_byte_c = cmd_arg_q[7:0];
      default: r7_byte_c = 8'h00;
    endcase
  end

  // Next-state and byte-level protocol handling
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_sr_d     = rx_sr_q;
    cmd_sr_d    = cmd_sr_q;
    cnt_d       = cnt_q;
    tx_d        = tx_q;
    miso_d      = miso_q;
    cmd_valid_d = 1'b0;
    cmd_idx_d   = cmd_idx_q;
    cmd_arg_d   = cmd_arg_q;
    init_d      = init_q;
    idle_d      = idle_q;
    app_d       = app_q;
    busy_d      = busy_q;
    r1_d        = r1_q;
    r7_d        = r7_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    blk_d       = blk_q;
    mem_we_c    = 1'b0;

    if (cs_sync_q) begin
      state_d   = HUNT;
      bit_cnt_d = 3'd0;
      cnt_d     = 9'd0;
      tx_d      = 8'hFF;
      miso_d    = 1'b1;
    end else begin
      if (sclk_fall_c) miso_d = tx_q[~bit_cnt_q];
      if (sclk_rise_c) begin
        rx_sr_d   = rx_byte_c[6:0];
        bit_cnt_d = bit_cnt_q + 3'd1;
        unique case (state_q)
          HUNT: begin
            if (!mosi_sync_q) begin
              state_d   = CMD;
              bit_cnt_d = 3'd1;
              cnt_d     = 9'd0;
              cmd_sr_d  = {cmd_sr_q[36:0], 1'b0};
            end else begin
              bit_cnt_d = 3'd0;
            end
          end
          CMD: begin
            if (cnt_q < 9'd5) cmd_sr_d = {cmd_sr_q[36:0], mosi_sync_q};
            if (bit_cnt_q == 3'd7) begin
              cnt_d = cnt_q + 9'd1;
              if (cnt_q == 9'd5) begin
                // Frame complete (CRC byte discarded): publish and decode
                cmd_valid_d = 1'b1;
                cmd_idx_d   = new_idx_c;
                cmd_arg_d   = new_arg_c;
                blk_d       = BLK_W'((new_arg_c >> 9) % BLOCKS);
                app_d       = 1'b0;
                r7_d        = 1'b0;
                rd_d        = 1'b0;
                wr_d        = 1'b0;
                tx_d        = 8'hFF;
                cnt_d       = 9'd0;
                state_d     = NCR;
                r1_d        = {5'b0, 1'b1, 1'b0, idle_q};
                case (new_idx_c)
                  6'd0: begin
                    idle_d = 1'b1;
                    init_d = 1'b0;
                    busy_d = BUSY_W'(INIT_BUSY_CNT);
                    r1_d   = 8'h01;
                  end
                  6'd8: begin
                    r1_d = {7'b0, idle_q};
                    r7_d = 1'b1;
                  end
                  6'd16: r1_d = {7'b0, idle_q};
                  6'd55: begin
                    r1_d  = {7'b0, idle_q};
                    app_d = 1'b1;
                  end
                  6'd41: begin
                    if (app_q) begin
                      busy_d = busy_dec_c;
                      if (busy_dec_c != '0) begin
                        r1_d = 8'h01;
                      end else begin
                        r1_d   = 8'h00;
                        idle_d = 1'b0;
                        init_d = 1'b1;
                      end
                    end
                  end
                  6'd17, 6'd24: begin
                    if (init_q) begin
                      r1_d = 8'h00;
                      rd_d = (new_idx_c == 6'd17);
                      wr_d = (new_idx_c == 6'd24);
                    end
                  end
                  default: ;
                endcase
              end
            end
          end
          NCR: begin
            if (bit_cnt_q == 3'd7) begin
              tx_d    = r1_q;
              cnt_d   = 9'd0;
              state_d = RESP;
            end
          end
          RESP: begin
            if (bit_cnt_q == 3'd7) begin
              if (r7_q && cnt_q < 9'd4) begin
                tx_d  = r7_byte_c;
                cnt_d = cnt_q + 9'd1;
              end else begin
                tx_d  = 8'hFF;
                cnt_d = 9'd0;
                if (rd_q)      state_d = RD_GAP;
                else if (wr_q) state_d = WR_WAIT_TOKEN;
                else           state_d = HUNT;
              end
            end
          end
          RD_GAP: begin
            if (bit_cnt_q == 3'd7) begin
              tx_d    = 8'hFE;
              state_d = RD_TOKEN;
            end
          end
          RD_TOKEN: begin
            if (bit_cnt_q == 3'd7) begin
              tx_d    = rd_data_q;
              cnt_d   = 9'd0;
              state_d = RD_DATA;
            end
          end
          RD_DATA: begin
            // rd_data_q already holds the byte after cnt_q
            if (bit_cnt_q == 3'd7) begin
              if (cnt_q == 9'd511) begin
                tx_d    = 8'hFF;
                cnt_d   = 9'd0;
                state_d = RD_CRC;
              end else begin
                tx_d  = rd_data_q;
                cnt_d = cnt_q + 9'd1;
              end
            end
          end
          RD_CRC: begin
            if (bit_cnt_q == 3'd7) begin
              if (cnt_q == 9'd0) begin
                cnt_d = 9'd1;
              end else begin
                cnt_d   = 9'd0;
                state_d = HUNT;
              end
            end
          end
          WR_WAIT_TOKEN: begin
            if (bit_cnt_q == 3'd7 && rx_byte_c == 8'hFE) begin
              cnt_d   = 9'd0;
              state_d = WR_DATA;
            end
          end
          WR_DATA: begin
            if (bit_cnt_q == 3'd7) begin
              mem_we_c = 1'b1;
              if (cnt_q == 9'd511) begin
                cnt_d   = 9'd0;
                state_d = WR_CRC;
              end else begin
                cnt_d = cnt_q + 9'd1;
              end
            end
          end
          WR_CRC: begin
            if (bit_cnt_q == 3'd7) begin
              if (cnt_q == 9'd0) begin
                cnt_d = 9'd1;
              end else begin
                tx_d    = 8'h05;
                cnt_d   = 9'd0;
                state_d = WR_DRESP;
              end
            end
          end
          WR_DRESP: begin
            if (bit_cnt_q == 3'd7) begin
              cnt_d = 9'd0;
              if (BUSY_BYTES == 0) begin
                tx_d    = 8'hFF;
                state_d = HUNT;
              end else begin
                tx_d    = 8'h00;
                state_d = WR_BUSY;
              end
            end
          end
          WR_BUSY: begin
            if (bit_cnt_q == 3'd7) begin
              if (cnt_q == 9'(BUSY_BYTES - 1)) begin
                tx_d    = 8'hFF;
                cnt_d   = 9'd0;
                state_d = HUNT;
              end else begin
                cnt_d = cnt_q + 9'd1;
              end
            end
          end
          default: state_d = HUNT;
        endcase
        if (state_d == HUNT) miso_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HUNT;
      bit_cnt_q   <= 3'd0;
      rx_sr_q     <= 7'd0;
      cmd_sr_q    <= 38'd0;
      cnt_q       <= 9'd0;
      tx_q        <= 8'hFF;
      miso_q      <= 1'b1;
      cmd_valid_q <= 1'b0;
      cmd_idx_q   <= 6'd0;
      cmd_arg_q   <= 32'd0;
      init_q      <= 1'b0;
      idle_q      <= 1'b1;
      app_q       <= 1'b0;
      busy_q      <= BUSY_W'(INIT_BUSY_CNT);
      r1_q        <= 8'h00;
      r7_q        <= 1'b0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      blk_q       <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_sr_q     <= rx_sr_d;
      cmd_sr_q    <= cmd_sr_d;
      cnt_q       <= cnt_d;
      tx_q        <= tx_d;
      miso_q      <= miso_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_idx_q   <= cmd_idx_d;
      cmd_arg_q   <= cmd_arg_d;
      init_q      <= init_d;
      idle_q      <= idle_d;
      app_q       <= app_d;
      busy_q      <= busy_d;
      r1_q        <= r1_d;
      r7_q        <= r7_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      blk_q       <= blk_d;
    end
  end

  // Block storage: not reset, read port continuously prefetches the next byte
  always_ff @(posedge clk) begin
    if (mem_we_c && !rst) mem_q[wr_addr_c] <= rx_byte_c;
    rd_data_q <= mem_q[rd_addr_c];
  end

  assign miso        = miso_q;
  assign cmd_valid   = cmd_valid_q;
  assign cmd_idx     = cmd_idx_q;
  assign cmd_arg     = cmd_arg_q;
  assign initialized = init_q;

endmodule

// File: tb/tb_sd_spi_responder.sv
// Directed bench for sd_spi_responder: init handshake, block write/read, errors,
// cs abort, block-index wrap and reset in the middle of a write.
module tb_sd_spi_responder;

  localparam int unsigned HALF = 30;

  logic        clk, rst, cs, sclk, mosi;
  logic        miso, cmd_valid, initialized;
  logic [5:0]  cmd_idx;
  logic [31:0] cmd_arg;
  logic [7:0]  rb;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned cv_cnt   = 0;

  sd_spi_responder #(.BLOCKS(8), .INIT_BUSY_CNT(2), .BUSY_BYTES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .cs         (cs),
    .sclk       (sclk),
    .mosi       (mosi),
    .miso       (miso),
    .cmd_valid  (cmd_valid),
    .cmd_idx    (cmd_idx),
    .cmd_arg    (cmd_arg),
    .initialized(initialized)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) if (cmd_valid) cv_cnt <= cv_cnt + 1;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Mode 0: mosi set while sclk low, miso sampled just before the rising edge
  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      mosi = tx[i];
      #HALF;
      rx[i] = miso;
      sclk = 1'b1;
      #HALF;
      sclk = 1'b0;
    end
    mosi = 1'b1;
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] exp);
    logic [7:0] r;
    spi_byte(8'hFF, r);
    check(tag, {24'd0, r}, {24'd0, exp});
  endtask

  task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg);
    logic [7:0] r;
    spi_byte({2'b01, idx}, r);
    spi_byte(arg[31:24], r);
    spi_byte(arg[23:16], r);
    spi_byte(arg[15:8], r);
    spi_byte(arg[7:0], r);
    spi_byte(8'h01, r);
  endtask

  task automatic cmd_r1(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                        input logic [7:0] exp_r1);
    int unsigned cv0;
    cv0 = cv_cnt;
    send_cmd(idx, arg);
    expect_byte({tag, ".ncr"}, 8'hFF);
    check({tag, ".pulse"}, cv_cnt - cv0, 32'd1);
    check({tag, ".idx"}, {26'd0, cmd_idx}, {26'd0, idx});
    check({tag, ".arg"}, cmd_arg, arg);
    expect_byte({tag, ".r1"}, exp_r1);
  endtask

  task automatic read_start(input string tag, input logic [31:0] arg);
    cmd_r1(tag, 6'd17, arg, 8'h00);
    expect_byte({tag, ".gap"}, 8'hFF);
    expect_byte({tag, ".tok"}, 8'hFE);
  endtask

  task automatic init_seq(input string tag);
    cmd_r1({tag, ".cmd55a"}, 6'd55, 32'd0, 8'h01);
    cmd_r1({tag, ".acmd41a"}, 6'd41, 32'h4000_0000, 8'h01);
    check({tag, ".init_mid"}, {31'd0, initialized}, 32'd0);
    cmd_r1({tag, ".cmd55b"}, 6'd55, 32'd0, 8'h01);
    cmd_r1({tag, ".acmd41b"}, 6'd41, 32'h4000_0000, 8'h00);
    check({tag, ".init_done"}, {31'd0, initialized}, 32'd1);
  endtask

  initial begin
    rst  = 1'b1;
    cs   = 1'b1;
    sclk = 1'b0;
    mosi = 1'b1;
    #100;
    check("rst.miso", {31'd0, miso}, 32'd1);
    check("rst.cmd_valid", {31'd0, cmd_valid}, 32'd0);
    check("rst.cmd_idx", {26'd0, cmd_idx}, 32'd0);
    check("rst.cmd_arg", cmd_arg, 32'd0);
    check("rst.init", {31'd0, initialized}, 32'd0);
    rst = 1'b0;
    #100;
    cs = 1'b0;
    #100;

    // Init handshake plus pre-init errors
    cmd_r1("cmd0", 6'd0, 32'd0, 8'h01);
    cmd_r1("cmd17_pre", 6'd17, 32'd0, 8'h05);
    cmd_r1("cmd41_noapp_pre", 6'd41, 32'd0, 8'h05);
    cmd_r1("cmd8", 6'd8, 32'h0000_01AA, 8'h01);
    expect_byte("cmd8.r7_0", 8'h00);
    expect_byte("cmd8.r7_1", 8'h00);
    expect_byte("cmd8.r7_2", 8'h01);
    expect_byte("cmd8.r7_3", 8'hAA);
    init_seq("init");

    // Errors after init
    cmd_r1("cmd5", 6'd5, 32'd0, 8'h04);
    cmd_r1("cmd41_noapp", 6'd41, 32'd0, 8'h04);
    cmd_r1("cmd16", 6'd16, 32'd512, 8'h00);

    // Block write at 0x400 (block 2)
    cmd_r1("wr", 6'd24, 32'h0000_0400, 8'h00);
    spi_byte(8'hFF, rb);
    spi_byte(8'hFC, rb);
    spi_byte(8'hFE, rb);
    for (int i = 0; i < 512; i++) spi_byte(8'(i), rb);
    spi_byte(8'hAA, rb);
    spi_byte(8'h55, rb);
    expect_byte("wr.dresp", 8'h05);
    for (int i = 0; i < 4; i++) expect_byte($sformatf("wr.busy%0d", i), 8'h00);
    expect_byte("wr.idle", 8'hFF);

    // Read aborted after 100 bytes and three bits of the next
    read_start("ab", 32'h0000_0400);
    for (int i = 0; i < 100; i++) begin
      spi_byte(8'hFF, rb);
      check($sformatf("ab.d%0d", i), {24'd0, rb}, i);
    end
    for (int b = 0; b < 3; b++) begin
      #HALF;
      sclk = 1'b1;
      #HALF;
      sclk = 1'b0;
    end
    #40;
    check("ab.miso_pre", {31'd0, miso}, 32'd0);
    cs = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("ab.miso_3clk", {31'd0, miso}, 32'd1);
    #4;
    #100;
    cs = 1'b0;
    #100;

    // Full read of the written block
    read_start("rd", 32'h0000_0400);
    for (int i = 0; i < 512; i++) begin
      spi_byte(8'hFF, rb);
      check($sformatf("rd.d%0d", i), {24'd0, rb}, i % 256);
    end
    expect_byte("rd.crc0", 8'hFF);
    expect_byte("rd.crc1", 8'hFF);
    cmd_r1("rd.after", 6'd16, 32'd512, 8'h00);

    // Reset in the middle of a write to block 0
    cmd_r1("mw", 6'd24, 32'd0, 8'h00);
    spi_byte(8'hFE, rb);
    for (int i = 0; i < 40; i++) spi_byte(8'hA5 ^ 8'(i), rb);
    #20;
    rst = 1'b1;
    #60;
    rst = 1'b0;
    #40;
    check("mw.init", {31'd0, initialized}, 32'd0);
    check("mw.miso", {31'd0, miso}, 32'd1);
    check("mw.cmd_idx", {26'd0, cmd_idx}, 32'd0);
    check("mw.cmd_arg", cmd_arg, 32'd0);
    cmd_r1("mw.cmd17", 6'd17, 32'h0000_1000, 8'h05);
    cmd_r1("mw.cmd0", 6'd0, 32'd0, 8'h01);
    init_seq("reinit");

    // 0x1000 selects block 8, which wraps to block 0
    read_start("wrap", 32'h0000_1000);
    for (int i = 0; i < 40; i++) begin
      spi_byte(8'hFF, rb);
      check($sformatf("wrap.d%0d", i), {24'd0, rb}, {24'd0, 8'hA5 ^ 8'(i)});
    end
    cs = 1'b1;
    #100;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
